// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants, pattern-mode enum and colour helpers for the VGA pattern generator
//
// Purpose: timing geometry, box limits, the pattern-mode enum and the colour-bar lookup
// used by vga_pattern_gen and vga_box_mover.
// Ports: none (package).
package vga_pkg;

  localparam logic [9:0] H_ACTIVE  = 10'd640;
  localparam logic [9:0] V_ACTIVE  = 10'd480;
  localparam logic [9:0] H_TOTAL   = 10'd800;
  localparam logic [9:0] V_TOTAL   = 10'd525;
  localparam logic [9:0] BOX_SIZE  = 10'd32;
  localparam logic [9:0] BOX_X_MAX = 10'd608;
  localparam logic [9:0] BOX_Y_MAX = 10'd448;

  typedef enum logic [1:0] {
    MODE_BARS     = 2'd0,
    MODE_CHECKER  = 2'd1,
    MODE_BOX      = 2'd2,
    MODE_GRADIENT = 2'd3
  } pattern_mode_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Eight 80-pixel bars; a comparison ladder avoids a divide by 80.
  function automatic rgb_t bar_colour(input logic [9:0] col);
    rgb_t c;
    if      (col < 10'd80)  c = 12'hFFF;  // white
    else if (col < 10'd160) c = 12'hFF0;  // yellow
    else if (col < 10'd240) c = 12'h0FF;  // cyan
    else if (col < 10'd320) c = 12'h0F0;  // green
    else if (col < 10'd400) c = 12'hF0F;  // magenta
    else if (col < 10'd480) c = 12'hF00;  // red
    else if (col < 10'd560) c = 12'h00F;  // blue
    else                    c = 12'h000;  // black
    return c;
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// rtl/vga_box_mover.sv - bouncing 32x32 box position, advanced once per frame
//
// Purpose: holds the box top-left corner and its travel directions; steps X by 2 and
// Y by 1 on each frame-start strobe, reflecting at the screen edges.
// Ports:
//   Clock25    in   pixel clock
//   Reset      in   synchronous active-high reset (box to 0,0 moving right/down)
//   FrameStart in   one-cycle strobe per frame
//   BoxX       out  10-bit box left column (0..608, even)
//   BoxY       out  10-bit box top line (0..448)
module vga_box_mover
  import vga_pkg::*;
(
  input  logic       Clock25,
  input  logic       Reset,
  input  logic       FrameStart,
  output logic [9:0] BoxX,
  output logic [9:0] BoxY
);

  logic [9:0] box_x_q, box_x_d;
  logic [9:0] box_y_q, box_y_d;
  logic       dir_right_q, dir_right_d;
  logic       dir_down_q, dir_down_d;

  // X and Y are evaluated independently, so a corner hit reverses both at once.
  always_comb begin
    box_x_d     = box_x_q;
    box_y_d     = box_y_q;
    dir_right_d = dir_right_q;
    dir_down_d  = dir_down_q;
    if (FrameStart) begin
      if (dir_right_q) begin
        if (box_x_q == BOX_X_MAX) begin
          dir_right_d = 1'b0;
          box_x_d     = BOX_X_MAX - 10'd2;
        end else begin
          box_x_d = box_x_q + 10'd2;
        end
      end else begin
        if (box_x_q == 10'd0) begin
          dir_right_d = 1'b1;
          box_x_d     = 10'd2;
        end else begin
          box_x_d = box_x_q - 10'd2;
        end
      end
      if (dir_down_q) begin
        if (box_y_q == BOX_Y_MAX) begin
          dir_down_d = 1'b0;
          box_y_d    = BOX_Y_MAX - 10'd1;
        end else begin
          box_y_d = box_y_q + 10'd1;
        end
      end else begin
        if (box_y_q == 10'd0) begin
          dir_down_d = 1'b1;
          box_y_d    = 10'd1;
        end else begin
          box_y_d = box_y_q - 10'd1;
        end
      end
    end
  end

  always_ff @(posedge Clock25) begin
    if (Reset) begin
      box_x_q     <= 10'd0;
      box_y_q     <= 10'd0;
      dir_right_q <= 1'b1;
      dir_down_q  <= 1'b1;
    end else begin
      box_x_q     <= box_x_d;
      box_y_q     <= box_y_d;
      dir_right_q <= dir_right_d;
      dir_down_q  <= dir_down_d;
    end
  end

  assign BoxX = box_x_q;
  assign BoxY = box_y_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - four-pattern VGA colour generator with two-stage pixel pipeline
//
// Purpose: turns sync-stage counters into registered 4:4:4 colour, with syncs delayed
// two cycles to stay aligned. Pattern mode and animation state change only at frame start.
// Ports:
//   Clock25           in   pixel clock
//   Reset             in   synchronous active-high reset
//   HorizontalCounter in   10-bit pixel column (0..799)
//   VerticalCounter   in   10-bit line (0..524)
//   HorizontalSync    in   active-low hsync from the sync stage
//   VerticalSync      in   active-low vsync from the sync stage
//   Mode              in   2-bit pattern request (bars/checker/box/gradient)
//   Red, Green, Blue  out  4-bit registered colour
//   HSyncOut          out  hsync delayed 2 cycles
//   VSyncOut          out  vsync delayed 2 cycles
module vga_pattern_gen
  import vga_pkg::*;
(
  input  logic       Clock25,
  input  logic       Reset,
  input  logic [9:0] HorizontalCounter,
  input  logic [9:0] VerticalCounter,
  input  logic       HorizontalSync,
  input  logic       VerticalSync,
  input  logic [1:0] Mode,
  output logic [3:0] Red,
  output logic [3:0] Green,
  output logic [3:0] Blue,
  output logic       HSyncOut,
  output logic       VSyncOut
);

  pattern_mode_e mode_q;
  logic [7:0]    frame_cnt_q;
  logic [9:0]    box_x, box_y;
  logic          frame_start, active, in_box;
  rgb_t          rgb_d, rgb_s1_q, rgb_s2_q;
  logic          hsync_s1_q, hsync_s2_q, vsync_s1_q, vsync_s2_q;

  // First blanking line, column 0: occurs once per frame; out-of-range counters never match.
  assign frame_start = (HorizontalCounter == 10'd0) && (VerticalCounter == V_ACTIVE);
  assign active      = (HorizontalCounter < H_ACTIVE) && (VerticalCounter < V_ACTIVE);

  // box + BOX_SIZE peaks at 640, so the 10-bit sums cannot wrap.
  assign in_box = (HorizontalCounter >= box_x) && (HorizontalCounter < box_x + BOX_SIZE) &&
                  (VerticalCounter >= box_y)   && (VerticalCounter < box_y + BOX_SIZE);

  vga_box_mover u_box_mover (
    .Clock25    (Clock25),
    .Reset      (Reset),
    .FrameStart (frame_start),
    .BoxX       (box_x),
    .BoxY       (box_y)
  );

  always_comb begin
    rgb_d = '0;
    if (active) begin
      case (mode_q)
        MODE_BARS:     rgb_d = bar_colour(HorizontalCounter);
        MODE_CHECKER:  rgb_d = (HorizontalCounter[5] ^ VerticalCounter[5]) ? 12'hFFF : 12'h000;
        MODE_BOX:      rgb_d = in_box ? 12'hF00 : 12'h004;
        MODE_GRADIENT: rgb_d = {HorizontalCounter[7:4], VerticalCounter[7:4], frame_cnt_q[5:2]};
        default:       rgb_d = '0;
      endcase
    end
  end

  always_ff @(posedge Clock25) begin
    if (Reset) begin
      mode_q      <= MODE_BARS;
      frame_cnt_q <= 8'd0;
      rgb_s1_q    <= '0;
      rgb_s2_q    <= '0;
      hsync_s1_q  <= 1'b1;
      hsync_s2_q  <= 1'b1;
      vsync_s1_q  <= 1'b1;
      vsync_s2_q  <= 1'b1;
    end else begin
      if (frame_start) begin
        mode_q      <= pattern_mode_e'(Mode);
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
      rgb_s1_q   <= rgb_d;
      rgb_s2_q   <= rgb_s1_q;
      hsync_s1_q <= HorizontalSync;
      hsync_s2_q <= hsync_s1_q;
      vsync_s1_q <= VerticalSync;
      vsync_s2_q <= vsync_s1_q;
    end
  end

  assign Red      = rgb_s2_q.r;
  assign Green    = rgb_s2_q.g;
  assign Blue     = rgb_s2_q.b;
  assign HSyncOut = hsync_s2_q;
  assign VSyncOut = vsync_s2_q;

endmodule
